// File: rtl/serial_to_parallel_converter.sv
// UART-style receiver: start, 8 data bits LSB first, optional odd parity, stop.
// Each word is presented on DO with a one-cycle DVALID pulse and error flags.
module serial_to_parallel_converter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       DCLK,
  input  logic       RST_N,
  input  logic       RXD,
  input  logic       CTRL_PARITY_EN,
  input  logic [1:0] CTRL_BAUD_RATE,
  output logic [7:0] DO,
  output logic       DVALID,
  output logic       PERR,
  output logic       FERR
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [2:0] SETTLE_MAX = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   rxd_s;
  logic                   rxd_q;
  logic [2:0]             settle;
  logic                   armed;
  state_t                 state;
  logic [12:0]            cnt;
  logic [12:0]            div;
  logic [12:0]            half;
  logic [2:0]             idx;
  logic [7:0]             shift;
  logic                   par_bit;
  logic                   par_en_q;
  logic [1:0]             baud_q;

  assign rxd_s = sync[SYNC_STAGES-1];
  assign armed = (settle == SETTLE_MAX);

  always_comb begin
    div = 13'd434;
    unique case (baud_q)
      2'b00: div = 13'd5208;
      2'b01: div = 13'd2604;
      2'b10: div = 13'd1302;
      2'b11: div = 13'd434;
    endcase
  end

  assign half = (div >> 1) + {12'd0, div[0]};

  // The synchronizer resets to 1, so edges are ignored until the
  // chain and the edge register both hold real line samples.
  always_ff @(posedge DCLK or negedge RST_N) begin
    if (!RST_N) begin
      sync   <= '1;
      rxd_q  <= 1'b1;
      settle <= 3'd0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], RXD};
      rxd_q <= rxd_s;
      if (!armed) settle <= settle + 3'd1;
    end
  end

  always_ff @(posedge DCLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      cnt      <= 13'd0;
      idx      <= 3'd0;
      shift    <= 8'h00;
      par_bit  <= 1'b0;
      par_en_q <= 1'b0;
      baud_q   <= 2'b00;
      DO       <= 8'h00;
      DVALID   <= 1'b0;
      PERR     <= 1'b0;
      FERR     <= 1'b0;
    end else begin
      DVALID <= 1'b0;
      unique case (state)
        IDLE: begin
          if (armed && rxd_q && !rxd_s) begin
            state    <= START;
            // count equals cycles elapsed since the edge cycle
            cnt      <= 13'd1;
            baud_q   <= CTRL_BAUD_RATE;
            par_en_q <= CTRL_PARITY_EN;
          end
        end
        START: begin
          if (cnt == half) begin
            cnt <= 13'd0;
            idx <= 3'd0;
            state <= rxd_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 13'd1;
          end
        end
        DATA: begin
          if (cnt == div) begin
            shift <= {rxd_s, shift[7:1]};
            cnt   <= 13'd0;
            idx   <= idx + 3'd1;
            if (idx == 3'd7) state <= par_en_q ? PARITY : STOP;
          end else begin
            cnt <= cnt + 13'd1;
          end
        end
        PARITY: begin
          if (cnt == div) begin
            par_bit <= rxd_s;
            cnt     <= 13'd0;
            state   <= STOP;
          end else begin
            cnt <= cnt + 13'd1;
          end
        end
        STOP: begin
          if (cnt == div) begin
            cnt    <= 13'd0;
            state  <= IDLE;
            DO     <= shift;
            DVALID <= 1'b1;
            FERR   <= ~rxd_s;
            PERR   <= par_en_q & ~(^shift ^ par_bit);
          end else begin
            cnt <= cnt + 13'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_to_parallel_converter.sv
// Bench for serial_to_parallel_converter: directed and random frames
// checked against a frame-level model of expected words and timing.
module tb_serial_to_parallel_converter;

  localparam int SYNC = 2;

  typedef struct {
    int         t;
    logic [7:0] d;
    logic       p;
    logic       f;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       pen = 1'b0;
  logic [1:0] baud = 2'b00;
  logic [7:0] dout;
  logic       dvalid;
  logic       perr;
  logic       ferr;

  int  cyc = 0;
  int  nvec = 0;
  int  nerr = 0;
  ev_t got_q[$];
  ev_t exp_q[$];
  ev_t mon_e;

  serial_to_parallel_converter #(.SYNC_STAGES(SYNC)) dut (
    .DCLK(clk),
    .RST_N(rst_n),
    .RXD(rxd),
    .CTRL_PARITY_EN(pen),
    .CTRL_BAUD_RATE(baud),
    .DO(dout),
    .DVALID(dvalid),
    .PERR(perr),
    .FERR(ferr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dvalid === 1'b1) begin
      mon_e.t = cyc;
      mon_e.d = dout;
      mon_e.p = perr;
      mon_e.f = ferr;
      got_q.push_back(mon_e);
    end
  end

  function automatic int nbit(input logic [1:0] b);
    case (b)
      2'b00:   return 5209;
      2'b01:   return 2605;
      2'b10:   return 1303;
      default: return 435;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_events(input string tag);
    chk({tag, " count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk({tag, " time"}, got_q[i].t, exp_q[i].t);
      chk({tag, " do"}, got_q[i].d, exp_q[i].d);
      chk({tag, " perr"}, got_q[i].p, exp_q[i].p);
      chk({tag, " ferr"}, got_q[i].f, exp_q[i].f);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b, input int n);
    rxd = b;
    repeat (n) @(negedge clk);
  endtask

  // Config is scrambled after the start bit to show it is captured per frame.
  task automatic send_frame(input logic [7:0] d, input logic p,
                            input logic pb, input logic sb);
    ev_t        e;
    int         n;
    logic [1:0] b;
    b = baud;
    pen = p;
    n = nbit(b);
    e.t = cyc + SYNC + 1 + n / 2 + (p ? 10 : 9) * n;
    e.d = d;
    e.p = p && ((($countones(d) + int'(pb)) % 2) == 0);
    e.f = !sb;
    exp_q.push_back(e);
    drive_bit(1'b0, n);
    baud = 2'($urandom);
    pen = 1'($urandom);
    for (int k = 0; k < 8; k++) drive_bit(d[k], n);
    if (p) drive_bit(pb, n);
    drive_bit(sb, n);
    rxd = 1'b1;
    baud = b;
    pen = p;
  endtask

  initial begin
    logic [7:0] rd;
    logic       rp;
    logic       rpb;
    logic       rsb;

    rst_n = 1'b0;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset do", dout, 8'h00);
    chk("reset dvalid", dvalid, 1'b0);
    chk("reset perr", perr, 1'b0);
    chk("reset ferr", ferr, 1'b0);
    rst_n = 1'b1;
    idle(10);

    baud = 2'b11;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    idle(20);
    check_events("a5");

    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    idle(20);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    idle(20);
    check_events("parity");

    baud = 2'b10;
    pen = 1'b0;
    drive_bit(1'b0, 100);
    idle(1400);
    check_events("false start");
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    idle(20);
    check_events("x81");

    baud = 2'b01;
    send_frame(8'h7E, 1'b0, 1'b0, 1'b0);
    idle(2605);
    check_events("ferr");
    chk("hold do", dout, 8'h7E);
    chk("hold ferr", ferr, 1'b1);

    baud = 2'b11;
    send_frame(8'h00, 1'b1, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1, 1'b1);
    idle(20);
    check_events("b2b");

    pen = 1'b0;
    drive_bit(1'b0, 435);
    for (int k = 0; k < 4; k++) drive_bit(1'b1, 435);
    drive_bit(1'b0, 100);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid rst do", dout, 8'h00);
    chk("mid rst dvalid", dvalid, 1'b0);
    chk("mid rst perr", perr, 1'b0);
    chk("mid rst ferr", ferr, 1'b0);
    repeat (435) @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * 435 - 102) @(negedge clk);
    drive_bit(1'b1, 435);
    idle(870);
    check_events("mid rst");

    for (int i = 0; i < 2; i++) begin
      rd = 8'($urandom);
      rp = 1'($urandom_range(0, 1));
      rpb = 1'($urandom_range(0, 1));
      rsb = ($urandom_range(0, 3) != 0);
      send_frame(rd, rp, rpb, rsb);
      idle(int'($urandom_range(2, 40)));
      check_events("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
